// File: rtl/qspi_dpram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// qspi_dpram_fifo_ctrl
//
// Single-clock FIFO controller that runs one external generic_dpram as a
// circular buffer. It sits between the bus-side register interface and the
// QSPI shift engine, and is used for both the TX and the RX data buffer.
// The RAM read port is combinational, so the head entry appears on rd_data
// in the same cycle its address is presented.
//
// Optional feature: define QSPI_FIFO_ERR_EN to add the sticky overflow and
// underflow flags and their err_clr input.
//
// Parameters
//   aw        RAM address width, DEPTH = 2**aw
//   dw        data width
//   AF_THRESH almost_full when level >= AF_THRESH
//   AE_THRESH almost_empty when level <= AE_THRESH
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    synchronous FIFO clear, overrides push and pop
//   wr_valid/wr_ready/wr_data  producer handshake
//   rd_valid/rd_ready/rd_data  consumer handshake, rd_data = ram_rdata
//   ram_we/ram_waddr/ram_wdata RAM write port
//   ram_raddr/ram_rdata        RAM read port
//   level                    occupancy, 0..DEPTH
//   full/empty/almost_full/almost_empty  registered status flags
//   overflow/underflow/err_clr (QSPI_FIFO_ERR_EN only) sticky error flags
// ---------------------------------------------------------------------------
module qspi_dpram_fifo_ctrl #(
    parameter int aw        = 4,
    parameter int dw        = 32,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [dw-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [dw-1:0] rd_data,
    output logic          ram_we,
    output logic [aw-1:0] ram_waddr,
    output logic [dw-1:0] ram_wdata,
    output logic [aw-1:0] ram_raddr,
    input  logic [dw-1:0] ram_rdata,
    output logic [aw:0]   level,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
`ifdef QSPI_FIFO_ERR_EN
    output logic          overflow,
    output logic          underflow,
    input  logic          err_clr,
`endif
    output logic          almost_empty
);

    localparam logic [aw:0] ONE  = (aw+1)'(1);
    localparam logic [aw:0] AF_L = (aw+1)'(AF_THRESH);
    localparam logic [aw:0] AE_L = (aw+1)'(AE_THRESH);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [aw:0] wr_ptr_q, wr_ptr_d;
    logic [aw:0] rd_ptr_q, rd_ptr_d;
    logic [aw:0] level_q, level_d;
    logic        push, pop;
    logic        ptr_full_d, ptr_empty_d;

    // Handshake and RAM port decode; ready/valid come only from registered state.
    assign wr_ready  = (state_q != ST_FULL);
    assign rd_valid  = (state_q != ST_EMPTY);
    assign push      = wr_valid & wr_ready & ~flush;
    assign pop       = rd_valid & rd_ready & ~flush;

    assign ram_we    = push;
    assign ram_waddr = wr_ptr_q[aw-1:0];
    assign ram_wdata = wr_data;
    assign ram_raddr = rd_ptr_q[aw-1:0];
    assign rd_data   = ram_rdata;

    // Pointer and level update.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + ONE;
            unique case ({push, pop})
                2'b10:   level_d = level_q + ONE;
                2'b01:   level_d = level_q - ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // Full when the wrap bits differ but the addresses match; empty when equal.
    assign ptr_empty_d = (wr_ptr_d == rd_ptr_d);
    assign ptr_full_d  = (wr_ptr_d[aw] != rd_ptr_d[aw]) &&
                         (wr_ptr_d[aw-1:0] == rd_ptr_d[aw-1:0]);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY:   if (push) state_d = ST_PARTIAL;
                ST_PARTIAL: begin
                    if (ptr_full_d)       state_d = ST_FULL;
                    else if (ptr_empty_d) state_d = ST_EMPTY;
                end
                ST_FULL:    if (pop) state_d = ST_PARTIAL;
                default:    state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together on the edge.
        if (rst) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign level        = level_q;
    assign full         = (state_q == ST_FULL);
    assign empty        = (state_q == ST_EMPTY);
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);

`ifdef QSPI_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    // Sticky error flags; err_clr beats a same-cycle set, flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_valid && (state_q == ST_FULL))  overflow_q  <= 1'b1;
            if (rd_ready && (state_q == ST_EMPTY)) underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_qspi_dpram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_qspi_dpram_fifo_ctrl
//
// Self-checking bench for qspi_dpram_fifo_ctrl (aw=4, dw=32). A behavioural
// RAM with combinational read is attached to the RAM ports. A reference
// model tracks level and pointers; written words are queued in a scoreboard
// and compared against rd_data when a pop occurs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qspi_dpram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, wr_valid, rd_ready;
    logic [31:0] wr_data;
    logic        wr_ready, rd_valid, ram_we;
    logic [31:0] rd_data, ram_wdata, ram_rdata;
    logic [3:0]  ram_waddr, ram_raddr;
    logic [4:0]  level;
    logic        full, empty, almost_full, almost_empty;
`ifdef QSPI_FIFO_ERR_EN
    logic        overflow, underflow, err_clr;
`endif

    int          checks   = 0;
    int          failures = 0;

    int          m_level;
    logic [4:0]  m_wp, m_rp;
    logic [31:0] sb[$];

    logic [31:0] ram [0:15];

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) ram[ram_waddr] <= ram_wdata;
    assign ram_rdata = ram[ram_raddr];

    qspi_dpram_fifo_ctrl #(.aw(4), .dw(32), .AF_THRESH(12), .AE_THRESH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .ram_wdata    (ram_wdata),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
`ifdef QSPI_FIFO_ERR_EN
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr),
`endif
        .almost_empty (almost_empty)
    );

    // One clock of stimulus, entered and left on a negative edge. Checks the
    // RAM port decode and the scoreboard head before the edge, then the
    // registered status against the model after it.
    task automatic drive_cycle(input logic wv, input logic [31:0] wd,
                               input logic rr, input logic fl);
        logic        push_e, pop_e;
        logic [31:0] exp_data;
        logic [10:0] exp_st, got_st;
        wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
        #1;
        push_e = wv && (m_level < 16) && !fl;
        pop_e  = rr && (m_level > 0) && !fl;
        checks++;
        if (ram_we !== push_e)
            begin failures++; $display("FAIL ram_we got=%b exp=%b", ram_we, push_e); end
        checks++;
        if (ram_raddr !== m_rp[3:0])
            begin failures++; $display("FAIL ram_raddr got=%0d exp=%0d", ram_raddr, m_rp[3:0]); end
        if (push_e) begin
            checks++;
            if (ram_waddr !== m_wp[3:0] || ram_wdata !== wd)
                begin failures++; $display("FAIL ram_write got=%0d/%h exp=%0d/%h", ram_waddr, ram_wdata, m_wp[3:0], wd); end
            sb.push_back(wd);
        end
        if (pop_e) begin
            exp_data = sb.pop_front();
            checks++;
            if (rd_data !== exp_data)
                begin failures++; $display("FAIL rd_data got=%h exp=%h", rd_data, exp_data); end
        end
        if (fl) begin
            m_level = 0; m_wp = '0; m_rp = '0; sb.delete();
        end else begin
            m_level = m_level + int'(push_e) - int'(pop_e);
            if (push_e) m_wp = m_wp + 5'd1;
            if (pop_e)  m_rp = m_rp + 5'd1;
        end
        @(negedge clk);
        exp_st = {5'(m_level), m_level == 0, m_level == 16, m_level >= 12,
                  m_level <= 4, m_level != 16, m_level != 0};
        got_st = {level, empty, full, almost_full, almost_empty, wr_ready, rd_valid};
        checks++;
        if (got_st !== exp_st)
            begin failures++; $display("FAIL status {lvl,e,f,af,ae,wrdy,rval} got=%b exp=%b", got_st, exp_st); end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
`ifdef QSPI_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        m_level = 0; m_wp = '0; m_rp = '0; sb.delete();
        #1;
        checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (level !== 5'd0)    begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (ram_we !== 1'b0)   begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        checks++; if (almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0)
            begin failures++; $display("FAIL reset_flags got ae=%b f=%b af=%b exp 1/0/0", almost_empty, full, almost_full); end
        @(negedge clk);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) drive_cycle(1'b1, 32'hA0 + i, 1'b0, 1'b0);
        checks++;
        if (full !== 1'b1 || wr_ready !== 1'b0 || level !== 5'd16)
            begin failures++; $display("FAIL fill_full got f=%b wrdy=%b lvl=%0d exp 1/0/16", full, wr_ready, level); end
        // Write into a full FIFO is ignored.
        drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checks++;
        if (level !== 5'd16)
            begin failures++; $display("FAIL fill_overwrite level got=%0d exp=16", level); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (empty !== 1'b1 || rd_valid !== 1'b0 || level !== 5'd0)
            begin failures++; $display("FAIL drain_empty got e=%b rval=%b lvl=%0d exp 1/0/0", empty, rd_valid, level); end
        // Read from an empty FIFO is ignored.
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 32'h5000 + i, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive_cycle(1'b1, 32'h5500 + i, 1'b1, 1'b0);
        checks++;
        if (level !== 5'd5)
            begin failures++; $display("FAIL b2b_level got=%0d exp=5", level); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 32'h9000 + i, 1'b0, 1'b0);
        checks++;
        if (level !== 5'd9)
            begin failures++; $display("FAIL flush_pre_level got=%0d exp=9", level); end
        drive_cycle(1'b1, 32'hF1F1_F1F1, 1'b1, 1'b1);
        #1;
        checks++;
        if (level !== 5'd0 || empty !== 1'b1 || ram_waddr !== 4'd0 || ram_raddr !== 4'd0)
            begin failures++; $display("FAIL flush_clear got lvl=%0d e=%b wa=%0d ra=%0d exp 0/1/0/0", level, empty, ram_waddr, ram_raddr); end
        @(negedge clk);
        drive_cycle(1'b1, 32'hC0DE_0001, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hC0DE_0002, 1'b1, 1'b0);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h7000 + i, 1'b0, 1'b0);
        wr_valid = 1'b1; rd_ready = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        m_level = 0; m_wp = '0; m_rp = '0; sb.delete();
        #1;
        checks++;
        if (level !== 5'd0 || empty !== 1'b1 || ram_waddr !== 4'd0 || ram_raddr !== 4'd0)
            begin failures++; $display("FAIL reset_mid got lvl=%0d e=%b wa=%0d ra=%0d exp 0/1/0/0", level, empty, ram_waddr, ram_raddr); end
        @(negedge clk);
        drive_cycle(1'b1, 32'hBEEF_0001, 1'b0, 1'b0);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

`ifdef QSPI_FIFO_ERR_EN
    task automatic test_err_flags();
        for (int i = 0; i < 16; i++) drive_cycle(1'b1, 32'hE0 + i, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b0)
            begin failures++; $display("FAIL err_ovf_early got=%b exp=0", overflow); end
        drive_cycle(1'b1, 32'hBAD0, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || level !== 5'd16)
            begin failures++; $display("FAIL err_overflow got ovf=%b lvl=%0d exp 1/16", overflow, level); end
        for (int i = 0; i < 16; i++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (underflow !== 1'b1 || overflow !== 1'b1)
            begin failures++; $display("FAIL err_underflow got udf=%b ovf=%b exp 1/1", underflow, overflow); end
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (underflow !== 1'b1 || overflow !== 1'b1)
            begin failures++; $display("FAIL err_flush_keep got udf=%b ovf=%b exp 1/1", underflow, overflow); end
        err_clr = 1'b1;
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        err_clr = 1'b0;
        checks++;
        if (underflow !== 1'b0 || overflow !== 1'b0)
            begin failures++; $display("FAIL err_clr got udf=%b ovf=%b exp 0/0", underflow, overflow); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef QSPI_FIFO_ERR_EN
        test_err_flags();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
